// File: rtl/seg7_scan_bcd.sv
// seg7_scan_bcd: binary-to-BCD converter (sequential shift-add-3) feeding a
// multiplexed N-digit 7-segment scanner with leading-zero blanking and
// selectable segment/anode polarity.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset (highest priority)
//   value_in  binary value to display, captured when load is accepted
//   load      capture request; accepted only while the converter is idle
//   busy      conversion in progress (load is ignored while high)
//   ovf       last loaded value exceeded 10^NUM_DIGITS-1
//   d         segments {g,f,e,d,c,b,a}, d[0] = a
//   a         one-hot digit enable, a[0] = least-significant digit
module seg7_scan_bcd #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned VAL_W          = 14,
    parameter int unsigned REFRESH_DIV    = 27000,
    parameter int unsigned BLANK_LZ       = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VAL_W-1:0]      value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  ovf,
    output logic [6:0]            d,
    output logic [NUM_DIGITS-1:0] a
);

    localparam int unsigned DISP_W    = 4 * NUM_DIGITS;
    localparam int unsigned SCR_W     = DISP_W + 4;
    localparam int unsigned BIT_CNT_W = $clog2(VAL_W + 1);
    localparam int unsigned REF_CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Internal nibble code for the dash glyph (never produced by BCD digits).
    localparam logic [3:0] NIB_DASH = 4'hA;

    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    state_t                 state, state_nxt;
    logic [VAL_W-1:0]       shreg, shreg_nxt;
    logic [SCR_W-1:0]       scratch, scratch_nxt, scratch_adj;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic                   wrap, wrap_nxt;
    logic [DISP_W-1:0]      disp, disp_nxt;
    logic                   ovf_nxt;

    // ------------------------------------------------------------------
    // Scanner state
    // ------------------------------------------------------------------
    logic [REF_CNT_W-1:0]   ref_cnt, ref_cnt_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [NUM_DIGITS-1:0]  zero_from;
    logic                   zero_run;
    logic [3:0]             sel_nib;
    logic                   sel_zero;
    logic                   sel_blank;
    logic [6:0]             seg_raw;
    logic [NUM_DIGITS-1:0]  an_onehot;
    logic [6:0]             d_nxt;
    logic [NUM_DIGITS-1:0]  a_nxt;

    // Active-high glyph for one display nibble.
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:     s = 7'h3F;
            4'd1:     s = 7'h06;
            4'd2:     s = 7'h5B;
            4'd3:     s = 7'h4F;
            4'd4:     s = 7'h66;
            4'd5:     s = 7'h6D;
            4'd6:     s = 7'h7D;
            4'd7:     s = 7'h07;
            4'd8:     s = 7'h7F;
            4'd9:     s = 7'h6F;
            NIB_DASH: s = 7'h40;
            default:  s = 7'h00;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every nibble (including the guard nibble).
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < int'(NUM_DIGITS) + 1; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter next-state and datapath.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        scratch_nxt = scratch;
        bit_cnt_nxt = bit_cnt;
        wrap_nxt    = wrap;
        disp_nxt    = disp;
        ovf_nxt     = ovf;

        case (state)
            ST_IDLE: begin
                if (load) begin
                    shreg_nxt   = value_in;
                    scratch_nxt = '0;
                    bit_cnt_nxt = '0;
                    wrap_nxt    = 1'b0;
                    state_nxt   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                scratch_nxt = {scratch_adj[SCR_W-2:0], shreg[VAL_W-1]};
                shreg_nxt   = shreg << 1;
                // A bit leaving the guard nibble means the value is far beyond
                // range; remember it so later shifts cannot hide it.
                wrap_nxt    = wrap | scratch_adj[SCR_W-1];
                bit_cnt_nxt = bit_cnt + 1'b1;
                if (bit_cnt == BIT_CNT_W'(VAL_W - 1)) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                // Any non-zero guard digit (or an earlier wrap) is >= 10^N.
                if (wrap || (scratch[SCR_W-1 -: 4] != 4'd0)) begin
                    ovf_nxt  = 1'b1;
                    disp_nxt = {NUM_DIGITS{NIB_DASH}};
                end else begin
                    ovf_nxt  = 1'b0;
                    disp_nxt = scratch[DISP_W-1:0];
                end
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Converter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            scratch <= '0;
            bit_cnt <= '0;
            wrap    <= 1'b0;
            disp    <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            scratch <= scratch_nxt;
            bit_cnt <= bit_cnt_nxt;
            wrap    <= wrap_nxt;
            disp    <= disp_nxt;
            ovf     <= ovf_nxt;
            busy    <= (state_nxt != ST_IDLE);
        end
    end

    // Free-running refresh divider and digit index.
    always_comb begin
        ref_cnt_nxt = ref_cnt + 1'b1;
        idx_nxt     = idx;
        if (ref_cnt == REF_CNT_W'(REFRESH_DIV - 1)) begin
            ref_cnt_nxt = '0;
            idx_nxt     = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // zero_from[k]: display digits k..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run     = zero_run && (disp_nxt[4*k +: 4] == 4'd0);
            zero_from[k] = zero_run;
        end
    end

    // Output decode from the next-cycle index and display so a and d always
    // describe the same digit and reflect new display contents immediately.
    always_comb begin
        sel_nib  = disp_nxt[3:0];
        sel_zero = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (IDX_W'(k) == idx_nxt) begin
                sel_nib  = disp_nxt[4*k +: 4];
                sel_zero = zero_from[k];
            end
        end

        sel_blank = (BLANK_LZ != 0) && !ovf_nxt && (idx_nxt != '0) && sel_zero;
        seg_raw   = sel_blank ? 7'h00 : seg_code(sel_nib);
        an_onehot = NUM_DIGITS'(1) << idx_nxt;

        d_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        a_nxt = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
    end

    // Scanner registers and pin drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt <= '0;
            idx     <= '0;
            a       <= AN_OFF;
            d       <= SEG_OFF;
        end else begin
            ref_cnt <= ref_cnt_nxt;
            idx     <= idx_nxt;
            a       <= a_nxt;
            d       <= d_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Self-checking bench for seg7_scan_bcd: directed scenarios followed by
// random load/value/reset traffic, compared every cycle against an
// arithmetic model of the display.
module tb_seg7_scan_bcd;

    localparam int ND = 4;
    localparam int VW = 14;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [VW-1:0] value_in;
    logic          load;
    logic          busy;
    logic          ovf;
    logic [6:0]    d;
    logic [ND-1:0] a;

    seg7_scan_bcd #(
        .NUM_DIGITS     (ND),
        .VAL_W          (VW),
        .REFRESH_DIV    (RD),
        .BLANK_LZ       (1),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .ovf      (ovf),
        .d        (d),
        .a        (a)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: displayed value as an integer, pending conversion
    // countdown, and edges since reset for the scan position.
    int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    int p10 [5]      = '{1, 10, 100, 1000, 10000};

    bit m_rst  = 1'b1;
    bit m_ovf  = 1'b0;
    int m_val  = 0;
    int m_pend = 0;
    int m_rem  = 0;
    int m_n    = 0;

    task automatic model_edge();
        if (reset) begin
            m_rst = 1'b1;
            m_ovf = 1'b0;
            m_val = 0;
            m_rem = 0;
            m_n   = 0;
        end else begin
            m_rst = 1'b0;
            m_n++;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_pend > 9999) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_ovf = 1'b0;
                        m_val = m_pend;
                    end
                end
            end else if (load) begin
                m_pend = int'(value_in);
                m_rem  = VW + 1;
            end
        end
    endtask

    function automatic int exp_seg(input int k);
        if (m_ovf) return 'h40;
        if (k > 0 && m_val < p10[k]) return 0;
        return seg_tab[(m_val / p10[k]) % 10];
    endfunction

    task automatic check_outputs();
        int         k;
        logic [3:0] ea;
        logic [6:0] ed;
        if (m_rst) begin
            chk("rst_a", {28'b0, a}, 32'hF);
            chk("rst_d", {25'b0, d}, 32'h7F);
            chk("rst_busy", {31'b0, busy}, 32'h0);
            chk("rst_ovf", {31'b0, ovf}, 32'h0);
        end else begin
            k  = (m_n / RD) % ND;
            ea = ~(4'b0001 << k);
            ed = ~(7'(exp_seg(k)));
            chk("a", {28'b0, a}, {28'b0, ea});
            chk("d", {25'b0, d}, {25'b0, ed});
            chk("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
            chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
        end
    endtask

    task automatic step(input logic rst, input logic ld, input int v);
        reset    = rst;
        load     = ld;
        value_in = v[VW-1:0];
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        logic rst_r;
        logic ld_r;
        int   v_r;
        int   sel;

        // Reset held for three cycles, then idle scan of "0".
        repeat (3) step(1'b1, 1'b0, 0);
        repeat (8) step(1'b0, 1'b0, 0);

        // Basic conversion and a full scan rotation.
        step(1'b0, 1'b1, 1234);
        repeat (40) step(1'b0, 1'b0, 0);

        // Second load while busy is dropped.
        step(1'b0, 1'b1, 7);
        repeat (3) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 9);
        repeat (25) step(1'b0, 1'b0, 0);

        // Overflow then recovery to zero.
        step(1'b0, 1'b1, 10000);
        repeat (20) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        repeat (20) step(1'b0, 1'b0, 0);

        // Interior zeros kept, leading zeros blanked.
        step(1'b0, 1'b1, 1005);
        repeat (20) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 5);
        repeat (20) step(1'b0, 1'b0, 0);

        // load held high: back-to-back conversions, busy-fall edge ignored.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, (i < 16) ? 321 : 4321);
        repeat (10) step(1'b0, 1'b0, 0);

        // Reset mid-conversion, then a load on the first post-reset cycle.
        step(1'b0, 1'b1, 9999);
        repeat (5) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 42);
        repeat (20) step(1'b0, 1'b0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 299) == 0);
            ld_r  = ($urandom_range(0, 7) == 0);
            sel   = int'($urandom_range(0, 3));
            if (sel == 0)      v_r = int'($urandom_range(0, 9));
            else if (sel == 1) v_r = int'($urandom_range(9990, 10010));
            else               v_r = int'($urandom_range(0, 16383));
            step(rst_r, ld_r, v_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
